dual_port_ram_param: RTL and testbench
======================================

Name: dual_port_ram_param

Overview:
Parametrised true dual-port synchronous RAM, successor to the fixed 8x16 dual_port_ram. Each port has its own enable, write enable, address, write data, registered read data and read-valid. Adds a post-reset memory-clear sweep with a busy flag, a selectable read-during-write mode, and address-collision detection. Used as the shared buffer between two independent agents in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of each word.
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words, derived and not overridable.
RDW_MODE, 0, read-during-write result: 0 = old data (read-first), 1 = new data (write-first).
INIT_VALUE, 0, DATA_WIDTH-bit value written to every word by the reset sweep.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
port_en_0  input  1  port 0 operation request
wr_en_0  input  1  port 0 write (1) / read (0), qualified by port_en_0
addr_in_0  input  ADDR_WIDTH  port 0 address
data_in_0  input  DATA_WIDTH  port 0 write data
data_out_0  output  DATA_WIDTH  port 0 registered data
valid_out_0  output  1  data_out_0 updated this cycle
port_en_1, wr_en_1, addr_in_1, data_in_1, data_out_1, valid_out_1: same as port 0, for port 1
init_busy  output  1  clear sweep in progress; port requests ignored
collision  output  1  same-address conflict registered this cycle

Behaviour:
- Reset (rst=1 at an edge): data_out_0/1=0, valid_out_0/1=0, collision=0, init_busy=1, FSM to INIT, sweep counter=0. Port requests are ignored. Reset must be applied after power-up; state before the first reset is undefined.
- FSM states:
  - INIT: on each edge with rst=0, write mem[cnt]=INIT_VALUE and increment cnt. On the edge where cnt==DEPTH-1, go to READY and set init_busy=0. init_busy is therefore high for exactly DEPTH edges after rst falls.
  - READY: serve port requests. Stays in READY until rst.
- Port operation: accepted only on an edge where the FSM is in READY and port_en_x=1.
  - Read: data_out_x <= mem[addr_in_x]. Latency 1 cycle. valid_out_x=1 for that one cycle.
  - Write: mem[addr_in_x] <= data_in_x. valid_out_x=1; data_out_x = old word if RDW_MODE=0, data_in_x if RDW_MODE=1.
  - port_en_x=0 or not READY: valid_out_x=0 and data_out_x holds its last value.
- Ports are fully independent when addresses differ; two writes in the same cycle to different addresses both commit.
- Collision: both ports accepted, addr_in_0==addr_in_1, and at least one wr_en. collision=1 for the following cycle only.
  - Write/write: port 0 data is stored and port 1 data is dropped. Both data_out follow the RDW rule using port 0's data.
  - Write/read: the reader gets the old word (RDW_MODE=0) or the writer's data (RDW_MODE=1).
  - Read/read on the same address is not a collision.
- Reset mid-operation: any in-flight result is discarded. Outputs clear on the next edge and the sweep restarts from cnt=0, so all contents revert to INIT_VALUE. Reset during INIT also restarts the sweep.
- Addresses span exactly DEPTH words, so no out-of-range case exists. The counter is ADDR_WIDTH+1 bits or compares against DEPTH-1; it must not wrap early.

Test Plan:
(DATA_WIDTH=8, ADDR_WIDTH=4, RDW_MODE=0, INIT_VALUE=0 unless stated.)
1. rst high 2 cycles, then low -> init_busy=1 for exactly 16 edges, then 0. A port 1 read of addr 5 -> data_out_1=0x00, valid_out_1=1 one cycle later.
2. Port 0 writes data i to addr i-1 for i=1..16, then port 1 reads addr 0..15 back-to-back -> data_out_1=0x01..0x10, each one cycle after its address, valid_out_1 continuously 1.
3. Same cycle: port 0 writes 0xAA to addr 3 and port 1 writes 0x55 to addr 3 -> collision=1 for one cycle. A later read of addr 3 -> 0xAA.
4. addr 7 holds 0x08. Port 0 writes 0x77 to addr 7 while port 1 reads addr 7 -> data_out_1=0x08, collision=1. Repeat with RDW_MODE=1 -> data_out_1=0x77.
5. Same cycle: port 0 writes 0x11 to addr 2 and port 1 writes 0x99 to addr 9 -> collision=0. Readback gives 0x11 and 0x99.
6. rst asserted mid-way through scenario 2's write burst -> outputs 0 next edge and init_busy=1 for 16 edges. Requests during that window give valid_out=0. Afterwards every address reads 0x00.

Source files
------------

// File: rtl/dual_port_ram_param.sv
// Parametrised true dual-port RAM with a post-reset clear sweep,
// selectable read-during-write behaviour and same-address collision flag.
module dual_port_ram_param #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  port_en_0,
  input  logic                  wr_en_0,
  input  logic [ADDR_WIDTH-1:0] addr_in_0,
  input  logic [DATA_WIDTH-1:0] data_in_0,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic                  valid_out_0,
  input  logic                  port_en_1,
  input  logic                  wr_en_1,
  input  logic [ADDR_WIDTH-1:0] addr_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic                  valid_out_1,
  output logic                  init_busy,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc_0, acc_1, wr_0, wr_1, same_addr, wr_1_commit;
  logic [DATA_WIDTH-1:0] rd_0, rd_1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && cnt == ADDR_WIDTH'(DEPTH - 1)) state_nxt = S_READY;
  end

  assign init_busy   = (state == S_INIT);
  assign acc_0       = (state == S_READY) && port_en_0;
  assign acc_1       = (state == S_READY) && port_en_1;
  assign wr_0        = acc_0 && wr_en_0;
  assign wr_1        = acc_1 && wr_en_1;
  assign same_addr   = (addr_in_0 == addr_in_1);
  // Port 0 wins a write/write collision, so port 1's write is dropped.
  assign wr_1_commit = wr_1 && !(wr_0 && same_addr);

  // Write-first mode forwards whichever write actually lands on the address.
  always_comb begin
    rd_0 = mem[addr_in_0];
    rd_1 = mem[addr_in_1];
    if (RDW_MODE != 0) begin
      if (wr_0)                   rd_0 = data_in_0;
      else if (wr_1 && same_addr) rd_0 = data_in_1;
      if (wr_0 && same_addr)      rd_1 = data_in_0;
      else if (wr_1)              rd_1 = data_in_1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) begin
        mem[cnt] <= INIT_VALUE;
      end else begin
        if (wr_1_commit) mem[addr_in_1] <= data_in_1;
        if (wr_0)        mem[addr_in_0] <= data_in_0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_0  <= '0;
      data_out_1  <= '0;
      valid_out_0 <= 1'b0;
      valid_out_1 <= 1'b0;
      collision   <= 1'b0;
    end else begin
      valid_out_0 <= acc_0;
      valid_out_1 <= acc_1;
      if (acc_0) data_out_0 <= rd_0;
      if (acc_1) data_out_1 <= rd_1;
      collision <= acc_0 && acc_1 && same_addr && (wr_en_0 || wr_en_1);
    end
  end

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Self-checking bench: a read-first and a write-first instance share stimulus
// and are compared against a word-array model of the RAM.
module tb_dual_port_ram_param;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          port_en_0 = 1'b0, wr_en_0 = 1'b0, port_en_1 = 1'b0, wr_en_1 = 1'b0;
  logic [AW-1:0] addr_in_0 = '0, addr_in_1 = '0;
  logic [DW-1:0] data_in_0 = '0, data_in_1 = '0;

  logic [DW-1:0] r_do0, r_do1, w_do0, w_do1;
  logic          r_v0, r_v1, r_busy, r_col, w_v0, w_v1, w_busy, w_col;

  always #5 clk = ~clk;

  dual_port_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .INIT_VALUE(8'h00)) u_dut_rf (
    .clk(clk), .rst(rst),
    .port_en_0(port_en_0), .wr_en_0(wr_en_0), .addr_in_0(addr_in_0), .data_in_0(data_in_0),
    .data_out_0(r_do0), .valid_out_0(r_v0),
    .port_en_1(port_en_1), .wr_en_1(wr_en_1), .addr_in_1(addr_in_1), .data_in_1(data_in_1),
    .data_out_1(r_do1), .valid_out_1(r_v1),
    .init_busy(r_busy), .collision(r_col));

  dual_port_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .INIT_VALUE(8'h00)) u_dut_wf (
    .clk(clk), .rst(rst),
    .port_en_0(port_en_0), .wr_en_0(wr_en_0), .addr_in_0(addr_in_0), .data_in_0(data_in_0),
    .data_out_0(w_do0), .valid_out_0(w_v0),
    .port_en_1(port_en_1), .wr_en_1(wr_en_1), .addr_in_1(addr_in_1), .data_in_1(data_in_1),
    .data_out_1(w_do1), .valid_out_1(w_v1),
    .init_busy(w_busy), .collision(w_col));

  // Reference model: word array plus count of sweep edges remaining.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_busy_left = 0;
  logic          e_v0 = 0, e_v1 = 0, e_col = 0, e_busy = 0;
  logic [DW-1:0] e_r0 = '0, e_r1 = '0, e_w0 = '0, e_w1 = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] obs_rf, obs_wf, exp_rf, exp_wf;
  assign obs_rf = {r_v0, r_v1, r_col, r_busy, r_do0, r_do1};
  assign obs_wf = {w_v0, w_v1, w_col, w_busy, w_do0, w_do1};
  assign exp_rf = {e_v0, e_v1, e_col, e_busy, e_r0, e_r1};
  assign exp_wf = {e_v0, e_v1, e_col, e_busy, e_w0, e_w1};

  // Read-first sees the array before this edge's writes, write-first after.
  task automatic model_edge();
    logic [DW-1:0] old_mem [DEPTH];
    if (rst) begin
      {e_v0, e_v1, e_col} = 3'b000;
      {e_r0, e_r1, e_w0, e_w1} = '0;
      m_busy_left = DEPTH;
      foreach (m_mem[i]) m_mem[i] = 8'h00;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      {e_v0, e_v1, e_col} = 3'b000;
    end else begin
      old_mem = m_mem;
      if (port_en_1 && wr_en_1) m_mem[addr_in_1] = data_in_1;
      if (port_en_0 && wr_en_0) m_mem[addr_in_0] = data_in_0;
      e_v0 = port_en_0;
      e_v1 = port_en_1;
      if (port_en_0) begin e_r0 = old_mem[addr_in_0]; e_w0 = m_mem[addr_in_0]; end
      if (port_en_1) begin e_r1 = old_mem[addr_in_1]; e_w1 = m_mem[addr_in_1]; end
      e_col = port_en_0 && port_en_1 && (addr_in_0 == addr_in_1) && (wr_en_0 || wr_en_1);
    end
    e_busy = (m_busy_left > 0);
  endtask

  task automatic tick(input logic en0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic en1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    port_en_0 = en0; wr_en_0 = w0; addr_in_0 = a0; data_in_0 = d0;
    port_en_1 = en1; wr_en_1 = w1; addr_in_1 = a1; data_in_1 = d1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    int edges;
    rst = 1'b1;
    tick(1, 1, 4'd1, 8'h12, 1, 0, 4'd2, 8'h00);
    tick(1, 0, 4'd3, 8'h00, 1, 1, 4'd4, 8'h34);
    n_checks++;
    if (obs_rf !== 20'h1_0000 || obs_wf !== 20'h1_0000) begin
      n_fail++;
      $display("[TB] FAIL reset_state rf=%h wf=%h required=%h", obs_rf, obs_wf, 20'h1_0000);
    end
    rst = 1'b0;
    edges = 0;
    while (r_busy === 1'b1 && edges < 40) begin
      tick(1, 1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom),
           1, 1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom));
      edges++;
      n_checks++;
      if (obs_rf !== exp_rf || obs_wf !== exp_wf) begin
        n_fail++;
        $display("[TB] FAIL sweep_ignore edge %0d rf=%h wf=%h required rf=%h wf=%h", edges, obs_rf, obs_wf, exp_rf, exp_wf);
      end
    end
    n_checks++;
    if (edges != DEPTH || w_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL sweep_length got %0d edges (wf busy=%b) required %0d", edges, w_busy, DEPTH);
    end
    tick(0, 0, 4'd0, 8'h00, 1, 0, 4'd5, 8'h00);
    n_checks++;
    if (r_v1 !== 1'b1 || r_do1 !== 8'h00 || w_v1 !== 1'b1 || w_do1 !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL first_read rf v=%b d=%h wf v=%b d=%h required v=1 d=00", r_v1, r_do1, w_v1, w_do1);
    end
  endtask

  task automatic test_fill_readback();
    for (int i = 1; i <= DEPTH; i++) begin
      tick(1, 1, 4'(i - 1), 8'(i), 0, 0, 4'd0, 8'h00);
      n_checks++;
      if (obs_rf !== exp_rf || obs_wf !== exp_wf || w_do0 !== 8'(i)) begin
        n_fail++;
        $display("[TB] FAIL fill_write %0d rf=%h wf=%h required rf=%h wf=%h", i, obs_rf, obs_wf, exp_rf, exp_wf);
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      tick(0, 0, 4'd0, 8'h00, 1, 0, 4'(a), 8'h00);
      n_checks++;
      if (r_v1 !== 1'b1 || r_do1 !== 8'(a + 1) || obs_rf !== exp_rf || obs_wf !== exp_wf) begin
        n_fail++;
        $display("[TB] FAIL readback addr %0d got v=%b d=%h required v=1 d=%h", a, r_v1, r_do1, 8'(a + 1));
      end
    end
    tick(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    n_checks++;
    if (r_v1 !== 1'b0 || r_do1 !== 8'h10 || w_v1 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_hold got v=%b d=%h required v=0 d=10", r_v1, r_do1);
    end
  endtask

  task automatic test_collision_ww();
    tick(1, 1, 4'd3, 8'hAA, 1, 1, 4'd3, 8'h55);
    n_checks++;
    if (r_col !== 1'b1 || w_col !== 1'b1 || r_do0 !== 8'h04 || r_do1 !== 8'h04 ||
        w_do0 !== 8'hAA || w_do1 !== 8'hAA) begin
      n_fail++;
      $display("[TB] FAIL ww_collision rf=%h wf=%h required col=1 rf 04/04 wf AA/AA", obs_rf, obs_wf);
    end
    tick(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    n_checks++;
    if (r_col !== 1'b0 || w_col !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ww_collision_pulse got %b/%b required 0", r_col, w_col);
    end
    tick(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    n_checks++;
    if (r_do0 !== 8'hAA || w_do0 !== 8'hAA || obs_rf !== exp_rf) begin
      n_fail++;
      $display("[TB] FAIL ww_winner got %h/%h required AA", r_do0, w_do0);
    end
  endtask

  task automatic test_collision_wr();
    tick(1, 1, 4'd7, 8'h77, 1, 0, 4'd7, 8'h00);
    n_checks++;
    if (r_do1 !== 8'h08 || w_do1 !== 8'h77 || r_col !== 1'b1 || w_col !== 1'b1 || r_v1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wr_collision got rf=%h wf=%h col=%b required rf=08 wf=77 col=1", r_do1, w_do1, r_col);
    end
    tick(1, 0, 4'd7, 8'h00, 1, 0, 4'd7, 8'h00);
    n_checks++;
    if (r_col !== 1'b0 || r_do0 !== 8'h77 || w_do1 !== 8'h77) begin
      n_fail++;
      $display("[TB] FAIL rr_same_addr got col=%b d=%h/%h required col=0 d=77", r_col, r_do0, w_do1);
    end
  endtask

  task automatic test_independent_writes();
    tick(1, 1, 4'd2, 8'h11, 1, 1, 4'd9, 8'h99);
    n_checks++;
    if (r_col !== 1'b0 || obs_rf !== exp_rf || obs_wf !== exp_wf) begin
      n_fail++;
      $display("[TB] FAIL indep_write rf=%h wf=%h required rf=%h wf=%h", obs_rf, obs_wf, exp_rf, exp_wf);
    end
    tick(1, 0, 4'd2, 8'h00, 1, 0, 4'd9, 8'h00);
    n_checks++;
    if (r_do0 !== 8'h11 || r_do1 !== 8'h99 || w_do0 !== 8'h11 || w_do1 !== 8'h99) begin
      n_fail++;
      $display("[TB] FAIL indep_readback got %h %h required 11 99", r_do0, r_do1);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a0, a1;
    for (int n = 0; n < 400; n++) begin
      a0 = 4'($urandom_range(15));
      a1 = ($urandom_range(1) == 1) ? a0 : 4'($urandom_range(15));
      tick(1'($urandom_range(1)), 1'($urandom_range(1)), a0, 8'($urandom),
           1'($urandom_range(1)), 1'($urandom_range(1)), a1, 8'($urandom));
      n_checks++;
      if (obs_rf !== exp_rf || obs_wf !== exp_wf) begin
        n_fail++;
        $display("[TB] FAIL random cycle %0d rf=%h wf=%h required rf=%h wf=%h", n, obs_rf, obs_wf, exp_rf, exp_wf);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 1; i <= 8; i++) tick(1, 1, 4'(i - 1), 8'(i), 1, 0, 4'(i), 8'h00);
    rst = 1'b1;
    tick(1, 1, 4'd8, 8'h09, 1, 0, 4'd0, 8'h00);
    rst = 1'b0;
    n_checks++;
    if (obs_rf !== 20'h1_0000 || obs_wf !== 20'h1_0000) begin
      n_fail++;
      $display("[TB] FAIL midreset_clear rf=%h wf=%h required %h", obs_rf, obs_wf, 20'h1_0000);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      tick(1, 1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom),
           1, 1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom));
      n_checks++;
      if (r_v0 !== 1'b0 || r_v1 !== 1'b0 || w_v0 !== 1'b0 || r_busy !== (k < DEPTH) || obs_rf !== exp_rf) begin
        n_fail++;
        $display("[TB] FAIL midreset_sweep edge %0d rf=%h required busy=%0d valid=0", k, obs_rf, (k < DEPTH));
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      tick(1, 0, 4'(a), 8'h00, 1, 0, 4'(DEPTH - 1 - a), 8'h00);
      n_checks++;
      if (r_do0 !== 8'h00 || r_do1 !== 8'h00 || w_do0 !== 8'h00 || r_v0 !== 1'b1 || obs_wf !== exp_wf) begin
        n_fail++;
        $display("[TB] FAIL midreset_clean addr %0d got %h %h v=%b required 00 00 v=1", a, r_do0, r_do1, r_v0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_readback();
    test_collision_ww();
    test_collision_wr();
    test_independent_writes();
    test_random();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
